eth_phy_10g_tx_if: RTL



---
 rtl/eth_phy_10g_tx_if.sv | 103 ++++++++++
 1 files changed

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R transmit SERDES interface: 64b/66b payload scrambler, optional PRBS31
// test pattern, optional bit reversal and output pipeline.
module eth_phy_10g_tx_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int HDR_WIDTH         = 2,
  parameter int BIT_REVERSE       = 0,
  parameter int SCRAMBLER_DISABLE = 0,
  parameter int PRBS31_ENABLE     = 0,
  parameter int SERDES_PIPELINE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  tx_prbs31_active,
  input  logic                  cfg_tx_prbs31_enable
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
  end
  if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_pipeline
    $error("eth_phy_10g_tx_if: SERDES_PIPELINE must be 0..4");
  end

  localparam bit PrbsEn = (PRBS31_ENABLE != 0);

  logic [57:0] scr_state, scr_next;
  logic [63:0] scr_data;
  logic [30:0] prbs_state, prbs_next;
  logic [65:0] prbs_word;
  logic        prbs_mode;
  logic [65:0] mux_word, stage_in;
  logic [SERDES_PIPELINE:0][65:0] pipe;

  // Unrolled serial scrambler: ext[57:0] are the previous 58 scrambled bits
  // (oldest at 0), ext[58+i] is scrambled bit i of this block.
  always_comb begin
    logic [121:0] ext;
    ext = {64'd0, scr_state};
    for (int i = 0; i < 64; i++)
      ext[58+i] = encoded_tx_data[i] ^ ext[i+19] ^ ext[i];
    scr_data = ext[121:58];
    scr_next = ext[121:64];
  end

  // PRBS31 generator unrolled over 66 bits; word bit 0 (hdr[0]) is first in sequence.
  always_comb begin
    logic [96:0] ext;
    ext = {66'd0, prbs_state};
    for (int i = 0; i < 66; i++)
      ext[31+i] = ext[i] ^ ext[i+3];
    prbs_word = ~ext[96:31];
    prbs_next = ext[96:66];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_state  <= '1;
      prbs_state <= '1;
      prbs_mode  <= 1'b0;
    end else begin
      scr_state <= scr_next;
      if (prbs_mode) prbs_state <= prbs_next;
      prbs_mode <= PrbsEn && cfg_tx_prbs31_enable;
    end
  end

  assign tx_prbs31_active = prbs_mode;

  // Reversal is pure wiring, so it is applied at the output-register input;
  // the registered value is identical to reversing after the register.
  always_comb begin
    if (prbs_mode)
      mux_word = prbs_word;
    else
      mux_word = {(SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data, encoded_tx_hdr};
    stage_in = mux_word;
    if (BIT_REVERSE != 0) begin
      for (int n = 0; n < 64; n++) stage_in[2+n] = mux_word[65-n];
      stage_in[0] = mux_word[1];
      stage_in[1] = mux_word[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int k = 1; k <= SERDES_PIPELINE; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign serdes_tx_data = pipe[SERDES_PIPELINE][65:2];
  assign serdes_tx_hdr  = pipe[SERDES_PIPELINE][1:0];

endmodule
